keyboard_input_decoder: RTL and testbench

KEYBOARD_INPUT_DECODER -- requirements
Module: keyboard_input_decoder

---
 rtl/keyboard_input_decoder.sv | 153 +++++++++++++++
 tb/tb_keyboard_input_decoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_input_decoder.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, frames bytes
// (start, 8 data LSB first, parity, stop) and tracks the A, D and Space keys.
//
// Ports:
//   clk, resetn            system clock, async active-low reset
//   ps2_clk, ps2_data      raw PS/2 lines (asynchronous to clk)
//   aPressed, dPressed     A (0x1C) / D (0x23) held
//   firePressed            Space (0x29) held
//   byteValid, byteOut     one-cycle strobe with the accepted byte
//   frameErr               one-cycle strobe per rejected/abandoned frame
//
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose
// data plus parity bits do not have odd parity.
module keyboard_input_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       aPressed,
    output logic       dPressed,
    output logic       firePressed,
    output logic       byteValid,
    output logic [7:0] byteOut,
    output logic       frameErr
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nx;
    logic          c_s1, c_s2, c_prev;
    logic          d_s1, d_s2;
    logic          fall;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [CW-1:0] idle_cnt;
    logic          brk_pend, ext_pend;
    logic          parity_ok;
    logic          accept, reject, timeout;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            c_prev <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
        end else begin
            c_s1   <= ps2_clk;
            c_s2   <= c_s1;
            c_prev <= c_s2;
            d_s1   <= ps2_data;
            d_s2   <= d_s1;
        end
    end

    assign fall = c_prev & ~c_s2;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{shreg, par_bit};
`else
    // Parity bit is captured but deliberately has no effect.
    assign parity_ok = par_bit | ~par_bit;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        timeout  = 1'b0;
        // idle_cnt == LIMIT with no edge now means TIMEOUT_CYCLES quiet cycles.
        if (state != IDLE && !fall && idle_cnt == LIMIT) begin
            state_nx = IDLE;
            timeout  = 1'b1;
        end else if (fall) begin
            unique case (state)
                IDLE:    if (!d_s2) state_nx = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
                PARITY:  state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    if (d_s2 && parity_ok) accept = 1'b1;
                    else                   reject = 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            idle_cnt    <= '0;
            brk_pend    <= 1'b0;
            ext_pend    <= 1'b0;
            aPressed    <= 1'b0;
            dPressed    <= 1'b0;
            firePressed <= 1'b0;
            byteValid   <= 1'b0;
            byteOut     <= '0;
            frameErr    <= 1'b0;
        end else begin
            byteValid <= accept;
            frameErr  <= reject | timeout;

            if (state_nx == IDLE || fall)
                idle_cnt <= '0;
            else if (idle_cnt != LIMIT)
                idle_cnt <= idle_cnt + 1'b1;

            if (fall && state == IDLE)
                bit_cnt <= '0;
            if (fall && state == DATA) begin
                shreg   <= {d_s2, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (fall && state == PARITY)
                par_bit <= d_s2;

            if (accept) begin
                byteOut <= shreg;
                if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else begin
                    // Extended codes share numbers with our keys; skip them.
                    if (!ext_pend) begin
                        case (shreg)
                            8'h1C:   aPressed    <= ~brk_pend;
                            8'h23:   dPressed    <= ~brk_pend;
                            8'h29:   firePressed <= ~brk_pend;
                            default: ;
                        endcase
                    end
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_keyboard_input_decoder.sv
// Self-checking bench for keyboard_input_decoder: directed key scenarios,
// timeout, mid-frame reset and randomized frames against a key-state model.
module tb_keyboard_input_decoder;
    localparam int TO   = 300;
    localparam int HALF = 6;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       aPressed, dPressed, firePressed;
    logic       byteValid, frameErr;
    logic [7:0] byteOut;

    int         n_checks = 0;
    int         n_fail = 0;
    int         bv_cnt = 0;
    int         fe_cnt = 0;
    logic [7:0] bv_last = '0;
    int         dv, de;
    bit         exp_acc;
    bit         m_a, m_d, m_f, m_brk, m_ext;

    always #5 clk = ~clk;

    keyboard_input_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .aPressed(aPressed), .dPressed(dPressed),
        .firePressed(firePressed), .byteValid(byteValid),
        .byteOut(byteOut), .frameErr(frameErr)
    );

    always @(negedge clk) begin
        if (byteValid) begin
            bv_cnt++;
            bv_last = byteOut;
        end
        if (frameErr) fe_cnt++;
    end

    task automatic model_reset();
        {m_a, m_d, m_f, m_brk, m_ext} = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (!m_ext) begin
                if (b == 8'h1C) m_a = !m_brk;
                if (b == 8'h23) m_d = !m_brk;
                if (b == 8'h29) m_f = !m_brk;
            end
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] b, input logic par,
                        input logic stop);
        int bv0, fe0;
        bv0 = bv_cnt;
        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop);
        ps2_data = 1'b1;
        repeat (8) @(posedge clk);
        dv = bv_cnt - bv0;
        de = fe_cnt - fe0;
        exp_acc = stop && (!PAR_EN || (^{b, par}));
        if (exp_acc) model_byte(b);
    endtask

    function automatic logic op(input logic [7:0] b);
        return ~^b;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({aPressed, dPressed, firePressed, byteValid, frameErr} !== 5'b0 ||
            byteOut !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: outs=%b byte=%h want 0",
                     {aPressed, dPressed, firePressed, byteValid, frameErr},
                     byteOut);
        end
        resetn = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
    endtask

    task automatic test_press_release();
        xfer(8'h1C, op(8'h1C), 1'b1);
        n_checks++;
        if (dv !== 1 || bv_last !== 8'h1C || de !== 0) begin
            n_fail++;
            $display("FAIL press_byte: dv=%0d byte=%h de=%0d want 1 1c 0",
                     dv, bv_last, de);
        end
        n_checks++;
        if (aPressed !== 1'b1) begin
            n_fail++;
            $display("FAIL press_a: aPressed=%b want 1", aPressed);
        end
        xfer(8'hF0, op(8'hF0), 1'b1);
        n_checks++;
        if (aPressed !== 1'b1 || bv_last !== 8'hF0) begin
            n_fail++;
            $display("FAIL break_prefix: a=%b byte=%h want 1 f0",
                     aPressed, bv_last);
        end
        xfer(8'h1C, op(8'h1C), 1'b1);
        n_checks++;
        if ({aPressed, dPressed, firePressed} !== 3'b000) begin
            n_fail++;
            $display("FAIL release_a: adf=%b want 000",
                     {aPressed, dPressed, firePressed});
        end
    endtask

    task automatic test_combo();
        xfer(8'h23, op(8'h23), 1'b1);
        xfer(8'h29, op(8'h29), 1'b1);
        n_checks++;
        if ({aPressed, dPressed, firePressed} !== 3'b011) begin
            n_fail++;
            $display("FAIL combo: adf=%b want 011",
                     {aPressed, dPressed, firePressed});
        end
        xfer(8'hE0, op(8'hE0), 1'b1);
        xfer(8'h23, op(8'h23), 1'b1);
        n_checks++;
        if ({aPressed, dPressed, firePressed} !== 3'b011 || dv !== 1) begin
            n_fail++;
            $display("FAIL ext_ignore: adf=%b dv=%0d want 011 1",
                     {aPressed, dPressed, firePressed}, dv);
        end
    endtask

    task automatic test_parity();
        xfer(8'h1C, 1'b1, 1'b1);
        n_checks++;
        if (aPressed !== !PAR_EN || dv !== int'(!PAR_EN) ||
            de !== int'(PAR_EN)) begin
            n_fail++;
            $display("FAIL parity: a=%b dv=%0d de=%0d want %b %0d %0d",
                     aPressed, dv, de, !PAR_EN, !PAR_EN, PAR_EN);
        end
        xfer(8'hF0, op(8'hF0), 1'b1);
        xfer(8'h1C, op(8'h1C), 1'b1);
        xfer(8'hF0, op(8'hF0), 1'b1);
        xfer(8'h23, op(8'h23), 1'b1);
        n_checks++;
        if ({aPressed, dPressed, firePressed} !== 3'b001) begin
            n_fail++;
            $display("FAIL release_ad: adf=%b want 001",
                     {aPressed, dPressed, firePressed});
        end
    endtask

    task automatic test_timeout();
        int fe0;
        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TO / 2) @(posedge clk);
        n_checks++;
        if (fe_cnt - fe0 !== 0) begin
            n_fail++;
            $display("FAIL timeout_early: errs=%0d want 0", fe_cnt - fe0);
        end
        repeat (TO) @(posedge clk);
        n_checks++;
        if (fe_cnt - fe0 !== 1 || firePressed !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err: errs=%0d fire=%b want 1 1",
                     fe_cnt - fe0, firePressed);
        end
        xfer(8'h23, op(8'h23), 1'b1);
        n_checks++;
        if (dPressed !== 1'b1 || dv !== 1 || bv_last !== 8'h23) begin
            n_fail++;
            $display("FAIL after_timeout: d=%b dv=%0d byte=%h want 1 1 23",
                     dPressed, dv, bv_last);
        end
    endtask

    task automatic test_random();
        logic [7:0] tbl [6];
        logic [7:0] b;
        logic       par, stop;
        tbl = '{8'h1C, 8'h23, 8'h29, 8'hF0, 8'hE0, 8'h00};
        for (int n = 0; n < 40; n++) begin
            b = tbl[$urandom_range(0, 5)];
            if (b == 8'h00) b = 8'($urandom);
            par  = ($urandom_range(0, 4) == 0) ? ~op(b) : op(b);
            stop = ($urandom_range(0, 9) != 0);
            xfer(b, par, stop);
            n_checks++;
            if (dv !== int'(exp_acc) || de !== int'(!exp_acc) ||
                (exp_acc && bv_last !== b)) begin
                n_fail++;
                $display("FAIL rand_frame %0d: dv=%0d de=%0d byte=%h want %0d %0d %h",
                         n, dv, de, bv_last, exp_acc, !exp_acc, b);
            end
            n_checks++;
            if ({aPressed, dPressed, firePressed} !== {m_a, m_d, m_f}) begin
                n_fail++;
                $display("FAIL rand_keys %0d: adf=%b want %b", n,
                         {aPressed, dPressed, firePressed}, {m_a, m_d, m_f});
            end
        end
    endtask

    task automatic test_midframe_reset();
        xfer(8'h1C, op(8'h1C), 1'b1);
        n_checks++;
        if (aPressed !== m_a || m_a !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_a: a=%b want 1", aPressed);
        end
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        n_checks++;
        if ({aPressed, dPressed, firePressed, byteValid, frameErr} !== 5'b0 ||
            byteOut !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: outs=%b byte=%h want 0",
                     {aPressed, dPressed, firePressed, byteValid, frameErr},
                     byteOut);
        end
        model_reset();
        #20 resetn = 1'b1;
        repeat (5) @(posedge clk);
        xfer(8'h1C, op(8'h1C), 1'b1);
        n_checks++;
        if (aPressed !== 1'b1 || dv !== 1 || de !== 0) begin
            n_fail++;
            $display("FAIL post_reset: a=%b dv=%0d de=%0d want 1 1 0",
                     aPressed, dv, de);
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_combo();
        test_parity();
        test_timeout();
        test_random();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
